// File: rtl/segment_score_decoder.sv
// Reads back a pair of active-low 7-segment digits (tens, units), waits for the
// pattern to settle, and recovers the binary score while flagging illegal patterns.
module segment_score_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic [6:0]           i_Seg_Tens,
    input  logic [6:0]           i_Seg_Units,
    output logic [5:0]           o_Score,
    output logic                 o_Score_Valid,
    output logic                 o_Score_Strobe,
    output logic                 o_Decode_Err,
    output logic [ERR_CNT_W-1:0] o_Err_Count,
    output logic [1:0]           o_Dbg_State
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam int CNT_W = 8;

    state_t               state_q;
    logic [6:0]           tens_q;
    logic [6:0]           units_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [5:0]           score_q;
    logic                 valid_q;
    logic                 strobe_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 seen_q;

    logic [4:0] tens_dec;
    logic [4:0] units_dec;
    logic [6:0] value;
    logic       decode_ok;
    logic       changed;
    logic       terminal;

    // Returns {legal, digit}; only the ten exact glyphs are accepted.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg_n);
        logic [6:0] seg;
        seg = ~seg_n;
        case (seg)
            7'h7E:   return {1'b1, 4'd0};
            7'h30:   return {1'b1, 4'd1};
            7'h6D:   return {1'b1, 4'd2};
            7'h79:   return {1'b1, 4'd3};
            7'h33:   return {1'b1, 4'd4};
            7'h5B:   return {1'b1, 4'd5};
            7'h5F:   return {1'b1, 4'd6};
            7'h70:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h7B:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    always_comb begin
        tens_dec  = seg_decode(tens_q);
        units_dec = seg_decode(units_q);
        // Full 7-bit value so 64..99 is rejected rather than wrapped.
        value     = 7'(tens_dec[3:0]) * 7'd10 + 7'(units_dec[3:0]);
        decode_ok = tens_dec[4] && units_dec[4] && (value <= 7'd63);
        changed   = ({i_Seg_Tens, i_Seg_Units} != {tens_q, units_q});
        terminal  = (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            tens_q    <= 7'h7F;
            units_q   <= 7'h7F;
            cnt_q     <= '0;
            score_q   <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            seen_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            // A change always wins, including on the terminal-count edge.
            if (changed) begin
                tens_q  <= i_Seg_Tens;
                units_q <= i_Seg_Units;
                cnt_q   <= '0;
                state_q <= SETTLE;
                valid_q <= 1'b0;
            end else if (state_q == SETTLE) begin
                if (terminal) begin
                    if (decode_ok) begin
                        score_q <= value[5:0];
                        valid_q <= 1'b1;
                        state_q <= LOCKED;
                        seen_q  <= 1'b1;
                        if (!seen_q || (value[5:0] != score_q)) strobe_q <= 1'b1;
                    end else begin
                        err_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= ERROR;
                        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign o_Score        = score_q;
    assign o_Score_Valid  = valid_q;
    assign o_Score_Strobe = strobe_q;
    assign o_Decode_Err   = err_q;
    assign o_Err_Count    = err_cnt_q;
    assign o_Dbg_State    = state_q;

endmodule
